// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM/IO port arbiter between instruction fetch and the load/store buffer
module mem_ctrl #(
    parameter logic [31:0] IO_ADDR_LO = 32'h30000,
    parameter logic [31:0] IO_ADDR_HI = 32'h30004
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if_en,
    input  logic [31:0] if_addr,
    output logic        if_rdy,
    output logic [31:0] if_data,
    input  logic        lsb_en,
    input  logic        lsb_wr,
    input  logic [1:0]  lsb_len,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_rdy,
    output logic [31:0] lsb_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t      state, state_n;
    logic        last_lsb, last_lsb_n;
    logic        is_lsb, is_lsb_n;
    logic [2:0]  cnt, cnt_n;
    logic [2:0]  nbytes, nbytes_n;
    logic [31:0] base, base_n;
    logic [31:0] wdata, wdata_n;
    logic [31:0] rbuf, rbuf_n;
    logic [31:0] mem_a_n;
    logic [7:0]  mem_dout_n;
    logic        if_rdy_n, lsb_rdy_n;
    logic [31:0] if_data_n, lsb_rdata_n;

    logic [31:0] merged;
    logic [7:0]  next_wbyte;
    logic        stall;
    logic        pick_lsb;
    logic        can_accept;

    // A write byte aimed at the IO window is held off while the IO buffer is full.
    assign stall    = io_buffer_full && (mem_a >= IO_ADDR_LO) && (mem_a <= IO_ADDR_HI);
    assign mem_wr   = rdy_in && (state == WRITE) && !stall;
    assign pick_lsb = lsb_en && (!if_en || !last_lsb);
    // The ready-pulse cycle is a forced bubble so a still-held request cannot re-issue.
    assign can_accept = !flush && !if_rdy && !lsb_rdy && (if_en || lsb_en);

    // mem_din carries the byte addressed two counter steps earlier.
    always_comb begin
        merged = rbuf;
        case (cnt)
            3'd2:    merged[7:0]   = mem_din;
            3'd3:    merged[15:8]  = mem_din;
            3'd4:    merged[23:16] = mem_din;
            3'd5:    merged[31:24] = mem_din;
            default: ;
        endcase
    end

    always_comb begin
        case (cnt)
            3'd0:    next_wbyte = wdata[15:8];
            3'd1:    next_wbyte = wdata[23:16];
            default: next_wbyte = wdata[31:24];
        endcase
    end

    always_comb begin
        state_n     = state;
        last_lsb_n  = last_lsb;
        is_lsb_n    = is_lsb;
        cnt_n       = cnt;
        nbytes_n    = nbytes;
        base_n      = base;
        wdata_n     = wdata;
        rbuf_n      = rbuf;
        mem_a_n     = mem_a;
        mem_dout_n  = mem_dout;
        if_rdy_n    = 1'b0;
        lsb_rdy_n   = 1'b0;
        if_data_n   = if_data;
        lsb_rdata_n = lsb_rdata;

        case (state)
            IDLE: begin
                mem_a_n = 32'd0;
                if (can_accept) begin
                    rbuf_n = 32'd0;
                    if (pick_lsb) begin
                        last_lsb_n = 1'b1;
                        is_lsb_n   = 1'b1;
                        base_n     = lsb_addr;
                        wdata_n    = lsb_wdata;
                        mem_a_n    = lsb_addr;
                        nbytes_n   = (lsb_len == 2'd0) ? 3'd1 : (lsb_len == 2'd1) ? 3'd2 : 3'd4;
                        if (lsb_wr) begin
                            state_n    = WRITE;
                            cnt_n      = 3'd0;
                            mem_dout_n = lsb_wdata[7:0];
                        end else begin
                            state_n = READ;
                            cnt_n   = 3'd1;
                        end
                    end else begin
                        last_lsb_n = 1'b0;
                        is_lsb_n   = 1'b0;
                        base_n     = if_addr;
                        mem_a_n    = if_addr;
                        nbytes_n   = 3'd4;
                        state_n    = READ;
                        cnt_n      = 3'd1;
                    end
                end
            end
            READ: begin
                if (flush) begin
                    state_n = IDLE;
                    mem_a_n = 32'd0;
                    cnt_n   = 3'd0;
                end else begin
                    rbuf_n = merged;
                    if (cnt < nbytes) begin
                        mem_a_n = base + {29'd0, cnt};
                        cnt_n   = cnt + 3'd1;
                    end else if (cnt == nbytes) begin
                        mem_a_n = 32'd0;
                        cnt_n   = cnt + 3'd1;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = 3'd0;
                        if (is_lsb) begin
                            lsb_rdy_n   = 1'b1;
                            lsb_rdata_n = merged;
                        end else begin
                            if_rdy_n  = 1'b1;
                            if_data_n = merged;
                        end
                    end
                end
            end
            WRITE: begin
                // Stores are committed, so flush has no effect here.
                if (!stall) begin
                    if (cnt == nbytes - 3'd1) begin
                        state_n    = IDLE;
                        mem_a_n    = 32'd0;
                        mem_dout_n = 8'd0;
                        cnt_n      = 3'd0;
                        lsb_rdy_n  = 1'b1;
                    end else begin
                        mem_a_n    = base + {29'd0, cnt + 3'd1};
                        mem_dout_n = next_wbyte;
                        cnt_n      = cnt + 3'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                mem_a_n = 32'd0;
                cnt_n   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state     <= IDLE;
            last_lsb  <= 1'b0;
            is_lsb    <= 1'b0;
            cnt       <= 3'd0;
            nbytes    <= 3'd0;
            base      <= 32'd0;
            wdata     <= 32'd0;
            rbuf      <= 32'd0;
            mem_a     <= 32'd0;
            mem_dout  <= 8'd0;
            if_rdy    <= 1'b0;
            lsb_rdy   <= 1'b0;
            if_data   <= 32'd0;
            lsb_rdata <= 32'd0;
        end else if (rdy_in) begin
            state     <= state_n;
            last_lsb  <= last_lsb_n;
            is_lsb    <= is_lsb_n;
            cnt       <= cnt_n;
            nbytes    <= nbytes_n;
            base      <= base_n;
            wdata     <= wdata_n;
            rbuf      <= rbuf_n;
            mem_a     <= mem_a_n;
            mem_dout  <= mem_dout_n;
            if_rdy    <= if_rdy_n;
            lsb_rdy   <= lsb_rdy_n;
            if_data   <= if_data_n;
            lsb_rdata <= lsb_rdata_n;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full;
    logic        if_en;
    logic [31:0] if_addr;
    logic        if_rdy;
    logic [31:0] if_data;
    logic        lsb_en, lsb_wr;
    logic [1:0]  lsb_len;
    logic [31:0] lsb_addr, lsb_wdata;
    logic        lsb_rdy;
    logic [31:0] lsb_rdata;

    int total = 0;
    int bad   = 0;

    logic [7:0] ram [0:262143];

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .if_en(if_en), .if_addr(if_addr), .if_rdy(if_rdy), .if_data(if_data),
        .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_len(lsb_len), .lsb_addr(lsb_addr),
        .lsb_wdata(lsb_wdata), .lsb_rdy(lsb_rdy), .lsb_rdata(lsb_rdata)
    );

    always #5 clk_in = ~clk_in;

    // RAM with one-cycle read latency; output held while the system is frozen.
    always @(posedge clk_in) begin
        if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
        if (rdy_in) mem_din <= ram[mem_a[17:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    initial begin
        logic [7:0] eb [4];
        rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
        if_en = 1'b0; if_addr = 32'd0;
        lsb_en = 1'b0; lsb_wr = 1'b0; lsb_len = 2'd0; lsb_addr = 32'd0; lsb_wdata = 32'd0;
        for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
        ram[0] = 8'h13;
        ram[4] = 8'h01; ram[5] = 8'h02; ram[6] = 8'h03; ram[7] = 8'h04;
        ram[8] = 8'hA0; ram[9] = 8'hB1; ram[10] = 8'hC2; ram[11] = 8'hD3;
        ram[32'h101] = 8'hFF; ram[32'h102] = 8'h80;

        tick(2);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        check("rst_if_rdy", {31'd0, if_rdy}, 32'd0);
        check("rst_lsb_rdy", {31'd0, lsb_rdy}, 32'd0);
        check("rst_if_data", if_data, 32'd0);
        check("rst_lsb_rdata", lsb_rdata, 32'd0);
        rst_in = 1'b0;
        tick(1);

        // Both requesters from reset: LSB first, then alternation.
        if_en = 1'b1; if_addr = 32'd4;
        lsb_en = 1'b1; lsb_wr = 1'b0; lsb_len = 2'd0; lsb_addr = 32'h101;
        tick(1); check("arb_first_lsb", mem_a, 32'h101);
        tick(2); check("arb_lsb_rdy", {31'd0, lsb_rdy}, 32'd1);
                 check("arb_lsb_data", lsb_rdata, 32'h000000FF);
        tick(2); check("arb_then_if", mem_a, 32'd4);
        tick(5); check("arb_if_rdy", {31'd0, if_rdy}, 32'd1);
                 check("arb_if_data", if_data, 32'h04030201);
        tick(2); check("arb_alt_lsb", mem_a, 32'h101);
        if_en = 1'b0;
        tick(2); check("arb_lsb_rdy2", {31'd0, lsb_rdy}, 32'd1);
        lsb_en = 1'b0;
        tick(2);

        // Word fetch from address 0.
        if_en = 1'b1; if_addr = 32'd0;
        for (int i = 0; i < 4; i++) begin
            tick(1); check("fetch_addr", mem_a, i);
        end
        tick(1); check("fetch_no_rdy_t5", {31'd0, if_rdy}, 32'd0);
                 check("fetch_idle_a", mem_a, 32'd0);
        tick(1); check("fetch_rdy_t6", {31'd0, if_rdy}, 32'd1);
                 check("fetch_data", if_data, 32'h00000013);
        if_en = 1'b0;
        tick(1); check("fetch_pulse_end", {31'd0, if_rdy}, 32'd0);
                 check("fetch_data_hold", if_data, 32'h00000013);
        tick(1);

        // Halfword load at 0x101.
        lsb_en = 1'b1; lsb_wr = 1'b0; lsb_len = 2'd1; lsb_addr = 32'h101;
        tick(1); check("half_a0", mem_a, 32'h101);
        tick(1); check("half_a1", mem_a, 32'h102);
        tick(1); check("half_a_idle", mem_a, 32'd0);
                 check("half_no_rdy", {31'd0, lsb_rdy}, 32'd0);
        tick(1); check("half_rdy", {31'd0, lsb_rdy}, 32'd1);
                 check("half_data", lsb_rdata, 32'h000080FF);
        lsb_en = 1'b0;
        tick(1);

        // Word store 0xDEADBEEF to 0x200.
        eb[0] = 8'hEF; eb[1] = 8'hBE; eb[2] = 8'hAD; eb[3] = 8'hDE;
        lsb_en = 1'b1; lsb_wr = 1'b1; lsb_len = 2'd2; lsb_addr = 32'h200; lsb_wdata = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("st_wr", {31'd0, mem_wr}, 32'd1);
            check("st_addr", mem_a, 32'h200 + i);
            check("st_byte", {24'd0, mem_dout}, {24'd0, eb[i]});
        end
        tick(1); check("st_rdy", {31'd0, lsb_rdy}, 32'd1);
                 check("st_wr_off", {31'd0, mem_wr}, 32'd0);
        lsb_en = 1'b0;
        tick(1); check("st_ram", {ram[32'h203], ram[32'h202], ram[32'h201], ram[32'h200]}, 32'hDEADBEEF);

        // Byte store into the IO window with a 3-cycle full buffer.
        io_buffer_full = 1'b1;
        lsb_en = 1'b1; lsb_wr = 1'b1; lsb_len = 2'd0; lsb_addr = 32'h30000; lsb_wdata = 32'h0000005A;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("io_stall_wr", {31'd0, mem_wr}, 32'd0);
            check("io_stall_a", mem_a, 32'h30000);
        end
        @(posedge clk_in); #1 io_buffer_full = 1'b0;
        @(negedge clk_in);
        check("io_wr", {31'd0, mem_wr}, 32'd1);
        check("io_byte", {24'd0, mem_dout}, 32'h5A);
        tick(1); check("io_rdy", {31'd0, lsb_rdy}, 32'd1);
        lsb_en = 1'b0;
        check("io_ram", {24'd0, ram[32'h30000]}, 32'h5A);
        tick(1);

        // Fetch frozen for two cycles by rdy_in.
        if_en = 1'b1; if_addr = 32'd4;
        tick(1); check("frz_a0", mem_a, 32'd4);
        tick(1); check("frz_a1", mem_a, 32'd5);
        rdy_in = 1'b0;
        tick(1); check("frz_hold", mem_a, 32'd5);
        tick(1); rdy_in = 1'b1;
        tick(1); check("frz_resume", mem_a, 32'd6);
        tick(2); check("frz_no_rdy", {31'd0, if_rdy}, 32'd0);
        tick(1); check("frz_rdy", {31'd0, if_rdy}, 32'd1);
                 check("frz_data", if_data, 32'h04030201);
        if_en = 1'b0;
        tick(1);

        // Flush during fetch byte 2, then a new fetch is accepted.
        if_en = 1'b1; if_addr = 32'd0;
        tick(3); check("fl_a2", mem_a, 32'd2);
        flush = 1'b1; if_addr = 32'd8;
        tick(1); check("fl_a_idle", mem_a, 32'd0);
                 check("fl_no_rdy", {31'd0, if_rdy}, 32'd0);
        flush = 1'b0;
        tick(1); check("fl_new_a", mem_a, 32'd8);
        tick(1); check("fl_old_suppressed", {31'd0, if_rdy}, 32'd0);
        tick(4); check("fl_new_rdy", {31'd0, if_rdy}, 32'd1);
                 check("fl_new_data", if_data, 32'hD3C2B1A0);
        if_en = 1'b0;
        tick(1);

        // Flush during a store does not abort it.
        lsb_en = 1'b1; lsb_wr = 1'b1; lsb_len = 2'd2; lsb_addr = 32'h300; lsb_wdata = 32'h11223344;
        tick(2); flush = 1'b1;
        tick(1); flush = 1'b0;
                 check("fst_wr", {31'd0, mem_wr}, 32'd1);
                 check("fst_a2", mem_a, 32'h302);
        tick(1); check("fst_a3", mem_a, 32'h303);
        tick(1); check("fst_rdy", {31'd0, lsb_rdy}, 32'd1);
        lsb_en = 1'b0;
        tick(1); check("fst_ram", {ram[32'h303], ram[32'h302], ram[32'h301], ram[32'h300]}, 32'h11223344);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
